// File: rtl/alu_operand_stage.sv
// Operand stage in front of the ALU: architectural register file with
// write-through reads, operand B mux, a pending-write scoreboard that
// stalls on RAW/WAW hazards, and a valid/ready ALU input register.
module alu_operand_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  localparam int AW        = $clog2(REG_NUM)
) (
  input  logic                  clk,
  input  logic                  resetn,
  // decode side
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [AW-1:0]         in_rs,
  input  logic [AW-1:0]         in_rt,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic                  in_use_imm,
  input  logic [2:0]            in_alu_op,
  input  logic [AW-1:0]         in_rd,
  input  logic                  in_rd_wen,
  // write-back port
  input  logic                  wb_wen,
  input  logic [AW-1:0]         wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  // ALU side
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_A,
  output logic [DATA_WIDTH-1:0] out_B,
  output logic [2:0]            out_alu_op,
  output logic [AW-1:0]         out_rd,
  output logic                  out_rd_wen
);

  logic [DATA_WIDTH-1:0] regs [REG_NUM];
  logic [REG_NUM-1:0]    pending_reg;
  logic [REG_NUM-1:0]    pending_next;
  logic [REG_NUM-1:0]    eff_pending;
  logic [DATA_WIDTH-1:0] rs_data;
  logic [DATA_WIDTH-1:0] rt_data;
  logic                  wb_hit;
  logic                  hazard;
  logic                  accept;

  // Register 0 is hard zero, so a write-back aimed at it does nothing.
  assign wb_hit = wb_wen && (wb_addr != '0);

  // Register file write port; register 0 is never written and stays zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_hit) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Combinational reads; a same-cycle write-back to the read address is forwarded.
  always_comb begin
    rs_data = regs[in_rs];
    rt_data = regs[in_rt];
    if (wb_hit && (wb_addr == in_rs)) rs_data = wb_data;
    if (wb_hit && (wb_addr == in_rt)) rt_data = wb_data;
    if (in_rs == '0) rs_data = '0;
    if (in_rt == '0) rt_data = '0;
  end

  // A register being written back this cycle no longer counts as pending.
  generate
    for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_eff_pending
      assign eff_pending[gi] = pending_reg[gi] && !(wb_wen && (wb_addr == AW'(gi)));
    end
  endgenerate

  assign hazard   = eff_pending[in_rs]
                  || (!in_use_imm && eff_pending[in_rt])
                  || (in_rd_wen && eff_pending[in_rd]);
  assign in_ready = !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Scoreboard update: write-back clears first, so a new producer's set wins.
  always_comb begin
    pending_next = pending_reg;
    if (wb_hit) pending_next[wb_addr] = 1'b0;
    if (accept && in_rd_wen && (in_rd != '0)) pending_next[in_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  // ALU input register: load on accept, drain when consumed, hold otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid  <= 1'b0;
      out_A      <= '0;
      out_B      <= '0;
      out_alu_op <= '0;
      out_rd     <= '0;
      out_rd_wen <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_A      <= rs_data;
      out_B      <= in_use_imm ? in_imm : rt_data;
      out_alu_op <= in_alu_op;
      out_rd     <= in_rd;
      out_rd_wen <= in_rd_wen;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed testbench for alu_operand_stage. Inputs change on the falling
// edge; in_ready is sampled 1ns later, registered outputs 1ns after the
// rising edge.
module tb_alu_operand_stage;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic [2:0]  in_alu_op;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic        wb_wen;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_A;
  logic [31:0] out_B;
  logic [2:0]  out_alu_op;
  logic [4:0]  out_rd;
  logic        out_rd_wen;

  int checks;
  int errors;

  alu_operand_stage #(.DATA_WIDTH(32), .REG_NUM(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_imm     (in_imm),
    .in_use_imm (in_use_imm),
    .in_alu_op  (in_alu_op),
    .in_rd      (in_rd),
    .in_rd_wen  (in_rd_wen),
    .wb_wen     (wb_wen),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_A      (out_A),
    .out_B      (out_B),
    .out_alu_op (out_alu_op),
    .out_rd     (out_rd),
    .out_rd_wen (out_rd_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present an instruction (or just its fields when valid=0).
  task automatic drive_insn(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic use_imm, input logic [31:0] imm,
                            input logic [2:0] op, input logic [4:0] rd, input logic rd_wen);
    in_valid   = v;
    in_rs      = rs;
    in_rt      = rt;
    in_use_imm = use_imm;
    in_imm     = imm;
    in_alu_op  = op;
    in_rd      = rd;
    in_rd_wen  = rd_wen;
  endtask

  task automatic drive_wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    wb_wen  = en;
    wb_addr = addr;
    wb_data = data;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_A !== 32'h0) begin errors++; $display("FAIL reset_A got %h want 0", out_A); end
    checks++; if (out_B !== 32'h0) begin errors++; $display("FAIL reset_B got %h want 0", out_B); end
    checks++; if (out_rd_wen !== 1'b0 || out_rd !== 5'd0 || out_alu_op !== 3'd0) begin
      errors++; $display("FAIL reset_ctl got op=%0d rd=%0d wen=%b want 0/0/0", out_alu_op, out_rd, out_rd_wen); end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic_read;
    @(negedge clk);
    drive_wb(1'b1, 5'd5, 32'h0000_1234);
    @(negedge clk);
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_insn(1'b1, 5'd5, 5'd0, 1'b0, 32'h0, 3'b010, 5'd0, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    $display("txn basic: A=%h B=%h op=%0d", out_A, out_B, out_alu_op);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", out_valid); end
    checks++; if (out_A !== 32'h0000_1234) begin errors++; $display("FAIL basic_A got %h want 00001234", out_A); end
    checks++; if (out_B !== 32'h0) begin errors++; $display("FAIL basic_B got %h want 0", out_B); end
    checks++; if (out_alu_op !== 3'b010) begin errors++; $display("FAIL basic_op got %0d want 2", out_alu_op); end
    @(negedge clk);
    drive_insn(1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 3'd0, 5'd0, 1'b0);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b want 0", out_valid); end
    checks++; if (out_A !== 32'h0000_1234) begin errors++; $display("FAIL basic_hold_A got %h want 00001234", out_A); end
  endtask

  task automatic test_write_through;
    @(negedge clk);
    drive_wb(1'b1, 5'd7, 32'hDEAD_BEEF);
    drive_insn(1'b1, 5'd7, 5'd7, 1'b0, 32'h0, 3'b001, 5'd0, 1'b0);
    @(posedge clk); #1;
    $display("txn write_through: A=%h B=%h", out_A, out_B);
    checks++; if (out_A !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wt_A got %h want deadbeef", out_A); end
    checks++; if (out_B !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wt_B got %h want deadbeef", out_B); end
    @(negedge clk);
    drive_wb(1'b1, 5'd0, 32'h0000_0055);
    drive_insn(1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 3'd0, 5'd0, 1'b0);
    @(negedge clk);
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_insn(1'b1, 5'd0, 5'd0, 1'b0, 32'h0, 3'b100, 5'd0, 1'b0);
    @(posedge clk); #1;
    $display("txn reg0: A=%h B=%h", out_A, out_B);
    checks++; if (out_A !== 32'h0 || out_B !== 32'h0) begin
      errors++; $display("FAIL reg0_read got A=%h B=%h want 0/0", out_A, out_B); end
    @(negedge clk);
    drive_insn(1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 3'd0, 5'd0, 1'b0);
  endtask

  task automatic test_raw_stall;
    // producer of r3
    @(negedge clk);
    drive_insn(1'b1, 5'd0, 5'd0, 1'b0, 32'h0, 3'b011, 5'd3, 1'b1);
    // consumer of r3 (also produces r4)
    @(negedge clk);
    drive_insn(1'b1, 5'd3, 5'd0, 1'b0, 32'h0, 3'b110, 5'd4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall%0d got %b want 0", i, in_ready); end
      @(negedge clk);
    end
    drive_wb(1'b1, 5'd3, 32'hCAFE_0003);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_wb_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    $display("txn raw: A=%h rd=%0d", out_A, out_rd);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL raw_valid got %b want 1", out_valid); end
    checks++; if (out_A !== 32'hCAFE_0003) begin errors++; $display("FAIL raw_A got %h want cafe0003", out_A); end
    checks++; if (out_rd !== 5'd4 || out_rd_wen !== 1'b1) begin
      errors++; $display("FAIL raw_rd got rd=%0d wen=%b want 4/1", out_rd, out_rd_wen); end
    @(negedge clk);
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_insn(1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 3'd0, 5'd0, 1'b0);
  endtask

  task automatic test_use_imm;
    // make r3 pending again (r4 is still pending from the previous test)
    @(negedge clk);
    drive_insn(1'b1, 5'd0, 5'd0, 1'b1, 32'h0, 3'b000, 5'd3, 1'b1);
    @(negedge clk);
    drive_insn(1'b0, 5'd0, 5'd3, 1'b0, 32'h0, 3'b000, 5'd0, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL imm_rt_hazard got %b want 0", in_ready); end
    drive_insn(1'b0, 5'd0, 5'd0, 1'b1, 32'h0, 3'b000, 5'd4, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL waw_hazard got %b want 0", in_ready); end
    drive_insn(1'b1, 5'd0, 5'd3, 1'b1, 32'hFFFF_FFF0, 3'b111, 5'd0, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL imm_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    $display("txn use_imm: A=%h B=%h", out_A, out_B);
    checks++; if (out_B !== 32'hFFFF_FFF0) begin errors++; $display("FAIL imm_B got %h want fffffff0", out_B); end
    checks++; if (out_A !== 32'h0) begin errors++; $display("FAIL imm_A got %h want 0", out_A); end
    // retire r3 and r4
    @(negedge clk);
    drive_insn(1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 3'd0, 5'd0, 1'b0);
    drive_wb(1'b1, 5'd3, 32'h0000_0033);
    @(negedge clk);
    drive_wb(1'b1, 5'd4, 32'h0000_0044);
    @(negedge clk);
    drive_wb(1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    drive_insn(1'b1, 5'd3, 5'd4, 1'b0, 32'h0, 3'b101, 5'd6, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    $display("txn bp_first: A=%h B=%h op=%0d", out_A, out_B, out_alu_op);
    checks++; if (out_A !== 32'h33 || out_B !== 32'h44) begin
      errors++; $display("FAIL bp_first got A=%h B=%h want 33/44", out_A, out_B); end
    @(negedge clk);
    drive_insn(1'b1, 5'd4, 5'd3, 1'b0, 32'h0, 3'b110, 5'd7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got %b want 0", i, in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_A !== 32'h33 || out_B !== 32'h44 || out_alu_op !== 3'b101) begin
        errors++; $display("FAIL bp_hold%0d got v=%b A=%h B=%h op=%0d want 1/33/44/5", i, out_valid, out_A, out_B, out_alu_op); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    $display("txn bp_second: A=%h B=%h op=%0d", out_A, out_B, out_alu_op);
    checks++; if (out_valid !== 1'b1 || out_A !== 32'h44 || out_B !== 32'h33 || out_alu_op !== 3'b110) begin
      errors++; $display("FAIL bp_second got v=%b A=%h B=%h op=%0d want 1/44/33/6", out_valid, out_A, out_B, out_alu_op); end
    @(negedge clk);
    drive_insn(1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 3'd0, 5'd0, 1'b0);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || out_A !== 32'h44) begin
      errors++; $display("FAIL bp_drain got v=%b A=%h want 0/44", out_valid, out_A); end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    out_ready = 1'b0;
    drive_insn(1'b1, 5'd0, 5'd0, 1'b0, 32'h0, 3'b001, 5'd3, 1'b1);
    @(negedge clk);
    drive_insn(1'b1, 5'd3, 5'd3, 1'b0, 32'h0, 3'b010, 5'd0, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ar_stall got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid got %b want 1", out_valid); end
    #1;
    resetn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_async_valid got %b want 0", out_valid); end
    drive_insn(1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 3'd0, 5'd0, 1'b0);
    @(negedge clk);
    resetn    = 1'b1;
    out_ready = 1'b1;
    drive_insn(1'b1, 5'd3, 5'd3, 1'b0, 32'h0, 3'b011, 5'd0, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    $display("txn after_reset: A=%h B=%h", out_A, out_B);
    checks++; if (out_valid !== 1'b1 || out_A !== 32'h0 || out_B !== 32'h0) begin
      errors++; $display("FAIL ar_read got v=%b A=%h B=%h want 1/0/0", out_valid, out_A, out_B); end
    @(negedge clk);
    drive_insn(1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 3'd0, 5'd0, 1'b0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    resetn    = 1'b0;
    out_ready = 1'b1;
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_insn(1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 3'd0, 5'd0, 1'b0);
    test_reset;
    test_basic_read;
    test_write_through;
    test_raw_stall;
    test_use_imm;
    test_backpressure;
    test_async_reset;
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
